// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_ctrl_pkg
//  Description : Shared types and helpers for the UART transmit/receive
//                controllers: FSM state encoding, parity helper and a
//                frame-length helper usable in localparam expressions.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

    // Transmit FSM states, fixed 3-bit encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    // Widest supported data field; narrower frames are zero-extended
    localparam int c_MAX_DATA_WIDTH = 8;

    // Parity over a zero-extended data word; zero padding never changes the XOR
    function automatic logic calc_parity(input logic [c_MAX_DATA_WIDTH-1:0] data,
                                         input logic                         odd);
        return (^data) ^ odd;
    endfunction

    // Number of clock cycles a complete frame occupies on the line
    function automatic int frame_len(input int clks_per_bit,
                                     input int data_width,
                                     input int parity_en,
                                     input int stop_bits);
        return (1 + data_width + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage : uart_ctrl_pkg
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_counter
//  Description : Per-bit cycle counter. Counts 0..CLKS_PER_BIT-1, wraps on
//                its own, and raises a bit-end strobe on the final count.
//                A clear input restarts the bit period (used on state entry).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_count;

    // Cycle counter: restart on clear or at the end of each bit period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || (r_count == c_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_bit_end = (r_count == c_LAST);

endmodule : uart_baud_counter
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Shares one UART TX line between two requesters. Arbitrates
//                round-robin in IDLE, captures the winning byte and parity,
//                then serialises start, data (LSB first), optional parity
//                and one or two stop bits, CLKS_PER_BIT cycles each.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    output logic [1:0]            req_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  gnt_id
);

    localparam int                 c_IDX_W      = $clog2(DATA_WIDTH);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(DATA_WIDTH - 1);
    localparam logic               c_PARITY_EN  = (PARITY_EN != 0);
    localparam logic               c_PARITY_ODD = (PARITY_ODD != 0);
    localparam logic               c_STOP_LAST  = (STOP_BITS == 2);

    uart_tx_state_e              r_state;
    uart_tx_state_e              w_state_next;
    logic [DATA_WIDTH-1:0]       r_shift;
    logic [DATA_WIDTH-1:0]       w_shift_next;
    logic [c_IDX_W-1:0]          r_idx;
    logic [c_IDX_W-1:0]          w_idx_next;
    logic                        r_stop_idx;
    logic                        w_stop_idx_next;
    logic                        r_parity;
    logic                        w_parity_next;
    logic                        r_gnt_id;
    logic                        w_gnt_id_next;
    logic                        r_last_gnt;
    logic                        w_last_gnt_next;
    logic                        r_tx;
    logic                        w_tx_next;
    logic                        r_busy;
    logic                        w_busy_next;

    logic [1:0]                  w_req_ready;
    logic                        w_grant_sel;
    logic [DATA_WIDTH-1:0]       w_grant_data;
    logic [c_MAX_DATA_WIDTH-1:0] w_parity_in;
    logic                        w_bit_end;
    logic                        w_cnt_clear;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_cnt_clear),
        .o_bit_end (w_bit_end)
    );

    // Round-robin arbiter: a lone request wins, a tie goes to the requester
    // not served last. Ready is masked in reset so nothing looks accepted
    // while the flops are held.
    always_comb begin
        w_grant_sel  = (req_valid == 2'b11) ? ~r_last_gnt : req_valid[1];
        w_grant_data = w_grant_sel ? req_data1 : req_data0;
        w_parity_in  = '0;
        w_parity_in[DATA_WIDTH-1:0] = w_grant_data;
        w_req_ready  = 2'b00;
        if (rst_n && (r_state == IDLE) && (req_valid != 2'b00)) begin
            w_req_ready = w_grant_sel ? 2'b10 : 2'b01;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, next-datapath and next-output logic. tx/busy are derived
    // from the next state so the registered line changes on the same edge
    // the state does (tx falls in the first cycle after accept).
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_idx_next      = r_idx;
        w_stop_idx_next = r_stop_idx;
        w_parity_next   = r_parity;
        w_gnt_id_next   = r_gnt_id;
        w_last_gnt_next = r_last_gnt;

        case (r_state)
            IDLE: begin
                if (w_req_ready != 2'b00) begin
                    w_state_next    = START;
                    w_shift_next    = w_grant_data;
                    w_parity_next   = calc_parity(w_parity_in, c_PARITY_ODD);
                    w_gnt_id_next   = w_grant_sel;
                    w_last_gnt_next = w_grant_sel;
                    w_idx_next      = '0;
                    w_stop_idx_next = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_next = {1'b0, r_shift[DATA_WIDTH-1:1]};
                    if (r_idx == c_IDX_LAST) begin
                        w_idx_next   = '0;
                        w_state_next = c_PARITY_EN ? PARITY : STOP;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_stop_idx == c_STOP_LAST) begin
                        w_stop_idx_next = 1'b0;
                        w_state_next    = IDLE;
                    end else begin
                        w_stop_idx_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Bit counter restarts on every state entry and is parked in IDLE
        w_cnt_clear = (r_state == IDLE) || (w_state_next != r_state);

        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = w_parity_next;
            default: w_tx_next = 1'b1;
        endcase

        w_busy_next = (w_state_next != IDLE);
    end

    // Datapath and registered outputs; reset aborts any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_parity   <= 1'b0;
            r_gnt_id   <= 1'b0;
            r_last_gnt <= 1'b1;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_shift    <= w_shift_next;
            r_idx      <= w_idx_next;
            r_stop_idx <= w_stop_idx_next;
            r_parity   <= w_parity_next;
            r_gnt_id   <= w_gnt_id_next;
            r_last_gnt <= w_last_gnt_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
        end
    end

    assign req_ready = w_req_ready;
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign gnt_id    = r_gnt_id;

endmodule : uart_tx_scheduler
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Self-checking bench. Two schedulers share the stimulus:
//                instance A (even parity, 1 stop) and instance B (odd
//                parity, 2 stops). A frame-level reference model predicts
//                every output each cycle; directed scenarios add literal
//                expectations on top.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int CLKS = 4;
    localparam int DW   = 8;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [7:0] req_data0 = 8'h00;
    logic [7:0] req_data1 = 8'h00;

    logic [1:0] rdy_a, rdy_b;
    logic       tx_a, tx_b, busy_a, busy_b, gnt_a, gnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .CLKS_PER_BIT (CLKS), .DATA_WIDTH (DW), .PARITY_EN (1),
        .PARITY_ODD   (0),    .STOP_BITS  (1)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .req_valid (req_valid),
        .req_data0 (req_data0), .req_data1 (req_data1),
        .req_ready (rdy_a), .tx (tx_a), .busy (busy_a), .gnt_id (gnt_a)
    );

    uart_tx_scheduler #(
        .CLKS_PER_BIT (CLKS), .DATA_WIDTH (DW), .PARITY_EN (1),
        .PARITY_ODD   (1),    .STOP_BITS  (2)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .req_valid (req_valid),
        .req_data0 (req_data0), .req_data1 (req_data1),
        .req_ready (rdy_b), .tx (tx_b), .busy (busy_b), .gnt_id (gnt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: on accept, the whole frame is laid out as a list of
    // bit levels; the line level in frame cycle c is bits[c / CLKS].
    // ------------------------------------------------------------------
    logic [15:0] m_bits  [2] = '{16'h0, 16'h0};
    int          m_nbits [2] = '{0, 0};
    int          m_cyc   [2] = '{0, 0};
    logic        m_last  [2] = '{1'b1, 1'b1};
    logic        m_gnt   [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin : model_cmp
        logic [1:0] d_rdy  [2];
        logic       d_tx   [2];
        logic       d_busy [2];
        logic       d_gnt  [2];
        logic       e_busy, e_tx, sel, odd;
        logic [1:0] e_rdy;
        logic [7:0] fd;
        int         stops;

        d_rdy[0] = rdy_a;  d_tx[0] = tx_a;  d_busy[0] = busy_a;  d_gnt[0] = gnt_a;
        d_rdy[1] = rdy_b;  d_tx[1] = tx_b;  d_busy[1] = busy_b;  d_gnt[1] = gnt_b;

        for (int k = 0; k < 2; k++) begin
            odd   = (k == 1);
            stops = (k == 1) ? 2 : 1;
            if (!rst_n) begin
                m_nbits[k] = 0;
                m_cyc[k]   = 0;
                m_last[k]  = 1'b1;
                m_gnt[k]   = 1'b0;
            end
            e_busy = (m_cyc[k] < m_nbits[k] * CLKS);
            e_tx   = e_busy ? m_bits[k][m_cyc[k] / CLKS] : 1'b1;
            e_rdy  = 2'b00;
            sel    = 1'b0;
            if (rst_n && !e_busy && (req_valid != 2'b00)) begin
                sel   = (req_valid == 2'b11) ? !m_last[k] : req_valid[1];
                e_rdy = sel ? 2'b10 : 2'b01;
            end

            check($sformatf("model_tx[%0d]", k),     d_tx[k],   e_tx);
            check($sformatf("model_busy[%0d]", k),   d_busy[k], e_busy);
            check($sformatf("model_ready[%0d]", k),  d_rdy[k],  e_rdy);
            check($sformatf("model_gnt_id[%0d]", k), d_gnt[k],  m_gnt[k]);

            // Advance to the state after the coming rising edge
            if (rst_n) begin
                if (e_busy) m_cyc[k]++;
                if (e_rdy != 2'b00) begin
                    fd = sel ? req_data1 : req_data0;
                    m_bits[k] = '0;
                    for (int i = 0; i < DW; i++) m_bits[k][1 + i] = fd[i];
                    m_bits[k][1 + DW] = (^fd) ^ odd;
                    for (int s = 0; s < stops; s++) m_bits[k][2 + DW + s] = 1'b1;
                    m_nbits[k] = 2 + DW + stops;
                    m_cyc[k]   = 0;
                    m_gnt[k]   = sel;
                    m_last[k]  = sel;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", {31'd0, (busy_a || busy_b)}, 32'd0);
        drive_slot();
    endtask

    // Samples the mid-point of each bit for 52 cycles after an accept edge
    task automatic capture(output logic [11:0] sa, output logic [11:0] sb,
                           output int ca, output int cb);
        sa = '0; sb = '0; ca = 0; cb = 0;
        for (int c = 1; c <= 52; c++) begin
            @(negedge clk);
            if (busy_a) ca++;
            if (busy_b) cb++;
            if (((c - 1) % CLKS) == 1) begin
                if ((c - 1) / CLKS < 11) sa[(c - 1) / CLKS] = tx_a;
                if ((c - 1) / CLKS < 12) sb[(c - 1) / CLKS] = tx_b;
            end
        end
    endtask

    task automatic wait_ready_a(input logic [1:0] want, output int cyc, output int busy_cnt);
        cyc = 0; busy_cnt = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (busy_a) busy_cnt++;
            if (rdy_a == want) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : directed
        logic [11:0] sa, sb;
        int          ca, cb, cyc, bc, bad, first_rdy;
        logic [1:0]  rdy_at_first;

        // Reset state, with both requesters already holding bytes
        req_valid = 2'b11; req_data0 = 8'h3C; req_data1 = 8'hC3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx_a", tx_a, 1);
        check("reset_busy_a", busy_a, 0);
        check("reset_ready_a", rdy_a, 2'b00);
        check("reset_gnt_a", gnt_a, 0);
        check("reset_tx_b", tx_b, 1);

        // Tie: device0 first, device1 at cycle 45, device0 again at 90
        drive_slot();
        rst_n = 1'b1;
        @(negedge clk);
        check("tie_first_ready", rdy_a, 2'b01);
        wait_ready_a(2'b10, cyc, bc);
        check("tie_dev1_accept_cycle", cyc, 45);
        check("tie_busy_cycles", bc, 44);
        check("tie_gnt_during_frame0", gnt_a, 0);
        wait_ready_a(2'b01, cyc, bc);
        check("tie_dev0_again_cycle", cyc, 45);
        check("tie_gnt_during_frame1", gnt_a, 1);
        drive_slot();
        req_valid = 2'b00;
        wait_idle();

        // Single frame 0xA5 from device0
        req_data0 = 8'hA5; req_valid = 2'b01;
        @(negedge clk);
        check("single_ready", rdy_a, 2'b01);
        drive_slot();
        req_valid = 2'b00;
        capture(sa, sb, ca, cb);
        check("single_bits_a", sa, 12'h54A);
        check("single_busy_a", ca, 44);
        check("single_gnt_a", gnt_a, 0);
        check("single_bits_b_odd2stop", sb, 12'hF4A);
        check("single_busy_b", cb, 48);
        wait_idle();

        // 0x00: odd parity gives 1 on B, even parity gives 0 on A
        req_data0 = 8'h00; req_valid = 2'b01;
        @(negedge clk);
        drive_slot();
        req_valid = 2'b00;
        capture(sa, sb, ca, cb);
        check("odd_bits_b", sb, 12'hE00);
        check("odd_busy_b", cb, 48);
        check("even_bits_a", sa, 12'h400);
        check("even_busy_a", ca, 44);
        wait_idle();

        // Mid-frame request changes are ignored by the frame in flight
        req_data0 = 8'h5A; req_data1 = 8'h77; req_valid = 2'b01;
        @(negedge clk);
        drive_slot();
        req_valid = 2'b00;
        sa = '0; bad = 0; first_rdy = 0; rdy_at_first = 2'b00;
        for (int c = 1; c <= 47; c++) begin
            @(negedge clk);
            if (((c - 1) % CLKS) == 1 && (c - 1) / CLKS < 11) sa[(c - 1) / CLKS] = tx_a;
            if (busy_a && rdy_a != 2'b00) bad++;
            if (rdy_a != 2'b00 && first_rdy == 0) begin
                first_rdy    = c;
                rdy_at_first = rdy_a;
            end
            drive_slot();
            if (c == 8)  begin req_data1 = 8'hFF; req_valid = 2'b10; end
            if (c == 20) req_valid = 2'b00;
            if (c == 24) begin req_valid = 2'b11; req_data0 = 8'h11; req_data1 = 8'h0F; end
            if (c == 30) req_data1 = 8'hC3;
            if (c == 46) req_valid = 2'b00;
        end
        check("midframe_data_a", sa[8:1], 8'h5A);
        check("midframe_ready_while_busy", bad, 0);
        check("midframe_dev1_accept_cycle", first_rdy, 45);
        check("midframe_dev1_ready", rdy_at_first, 2'b10);
        wait_idle();

        // Reset during DATA (cycle 15), then a tie goes to device0
        req_data0 = 8'h96; req_valid = 2'b01;
        @(negedge clk);
        drive_slot();
        req_valid = 2'b00;
        repeat (14) @(posedge clk);
        #1;
        check("pre_reset_busy_a", busy_a, 1);
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        check("midreset_tx_a", tx_a, 1);
        check("midreset_busy_a", busy_a, 0);
        check("midreset_ready_a", rdy_a, 2'b00);
        check("midreset_tx_b", tx_b, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_tie_a", rdy_a, 2'b01);
        check("post_reset_tie_b", rdy_b, 2'b01);
        drive_slot();
        req_valid = 2'b00;
        wait_idle();

        // No request for 100 cycles
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || rdy_a !== 2'b00 ||
                tx_b !== 1'b1 || busy_b !== 1'b0 || rdy_b !== 2'b00) bad++;
        end
        check("no_request_quiet", bad, 0);

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 2000; c++) begin
            drive_slot();
            rst_n = 1'b1;
            if ($urandom_range(0, 7) == 0) req_valid = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) req_data0 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req_data1 = 8'($urandom);
            if ($urandom_range(0, 699) == 0) rst_n = 1'b0;
        end
        drive_slot();
        rst_n = 1'b1;
        req_valid = 2'b00;
        wait_idle();
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_scheduler
`default_nettype wire

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Synthesizable transmit scheduler that shares one UART TX line between two requesters (device0 and device1) in the UART AVIP HDL top. It arbitrates byte requests round-robin and captures the winning byte. It then serialises that byte as a start bit, data bits LSB first, an optional parity bit and one or two stop bits, each held for a programmable number of clock cycles. The `tx` output drives `uart_if` so the existing device monitor BFMs can sample it.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per bit period; legal range ≥ 2.
- `DATA_WIDTH`, 8: data bits per frame; legal values 5–8.
- `PARITY_EN`, 1: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: bit i is high while requester i holds a byte.
- `req_data0` in DATA_WIDTH: byte from device0.
- `req_data1` in DATA_WIDTH: byte from device1.
- `req_ready` out 2: one-hot accept; bit i high means requester i's byte is taken at this edge.
- `tx` out 1: serial line; idles high.
- `busy` out 1: high from the cycle after accept until the last stop-bit cycle, inclusive.
- `gnt_id` out 1: index of the requester whose frame is on the line; holds its value when idle.

## Operation
- FSM states are IDLE, START, DATA, PARITY, STOP.
- A bit counter counts 0..CLKS_PER_BIT-1. A bit-end strobe fires when the counter reaches CLKS_PER_BIT-1. The counter clears on every state entry.
- IDLE: `req_ready` is combinational and valid only in IDLE.
  - If exactly one `req_valid` bit is high, that requester is granted.
  - If both are high, the requester other than `last_gnt` is granted.
  - On the accept edge, the granted data is loaded into the shift register, `gnt_id` and `last_gnt` are updated, and the state becomes START.
- START: `tx`=0 for one bit period, then DATA.
- DATA: `tx` = shift register bit 0.
  - The register shifts right at each bit end.
  - The data index counts 0..DATA_WIDTH-1.
  - After the last data bit, the next state is PARITY if PARITY_EN, else STOP.
- PARITY: `tx` = XOR of the captured data, inverted when PARITY_ODD. Parity is computed at capture, not from the shifted register.
- STOP: `tx`=1 for STOP_BITS bit periods, then IDLE.
- Requester data is not sampled after the accept edge. Changes to `req_data*` or `req_valid` mid-frame have no effect.
- A requester that drops `req_valid` before it is granted loses nothing; no request is queued inside the block.

## Timing
- Reset values: `tx`=1, `busy`=0, `req_ready`=0, `gnt_id`=0, state=IDLE, counters=0, `last_gnt`=1 (device0 wins the first tie).
- Asserting `rst_n` mid-frame aborts the frame immediately: `tx` goes to 1 asynchronously and the partial frame is not resumed.
- Accept-to-start latency: `tx` falls in the first cycle after the accept edge.
- Frame length is F = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles of `busy`=1.
- Back-to-back frames: after the last stop cycle, at least one IDLE cycle occurs with `tx`=1 and `busy`=0. Request-to-request spacing is therefore F+1 cycles.
- `req_ready` is never high while `busy`=1. At most one `req_ready` bit is high in any cycle.
- `tx` is registered and glitch-free. `req_ready` is the only combinational output.

## Structure
- Shared package `uart_ctrl_pkg` holds:
  - the state enum `uart_tx_state_e` (IDLE, START, DATA, PARITY, STOP);
  - the parity function `calc_parity(data, odd)`;
  - a localparam helper for frame length.
- Sub-module `uart_baud_counter`: the per-bit cycle counter with a clear input and a bit-end strobe output. It is reused by the planned RX controller.
- Arbiter and FSM live in `uart_tx_scheduler`; no further hierarchy.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_WIDTH=8, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=1, so F=44.
- **Single frame.** device0 sends 0xA5.
  - `req_ready`=2'b01 for one cycle, then `busy` for 44 cycles.
  - `tx` bit sequence is 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit 4 cycles.
  - `gnt_id`=0.
- **Tie.** Both requesters are valid from reset with 0x3C and 0xC3.
  - device0 is served first. device1 is accepted in the first IDLE cycle after device0's frame (cycle 45 after the first accept).
  - A second tie is then won by device0, confirming round-robin alternation.
- **Odd parity and two stop bits.** Set PARITY_ODD=1, STOP_BITS=2 and send 0x00.
  - Parity bit is 1.
  - Two stop periods of 4 cycles each; `busy` lasts 48 cycles.
- **Mid-frame request change.** device1 changes `req_data1` and toggles `req_valid` during device0's frame.
  - The serialised data equals device0's captured byte.
  - device1 is accepted only after `busy` falls.
- **Reset during DATA.** Drop `rst_n` at cycle 15 of a frame.
  - `tx`=1, `busy`=0, `req_ready`=0 immediately.
  - After release, the next tie is granted to device0.
- **No request.** Hold `req_valid`=0 for 100 cycles.
  - `tx` stays 1, `busy` stays 0, `req_ready` stays 0.
